// File: rtl/pwm_pkg.sv
// pwm_pkg: shared PWM widths, control-register bit indices, divider mode and divisor helper
package pwm_pkg;
    localparam int DIV_W = 16;
    localparam int CTRL_EN = 0;
    localparam int CTRL_CNT_EN = 1;
    localparam int CTRL_OUT_EN = 2;
    localparam int CTRL_DUTY_SEL = 3;
    localparam int CTRL_SRST = 4;
    typedef enum logic {IDLE, RUN} mode_e;
    function automatic logic [DIV_W-1:0] last_cnt(input logic [DIV_W-1:0] d);
        return d > 1 ? d - 1'b1 : '0;
    endfunction
endpackage

// File: rtl/pwm_clk_div_if.sv
// pwm_clk_div_if: divider bundle; master drives div_en/div_clr/divisor_i/divisor_wr, slave returns tick_o/div_active_o/pend_o/tick_cnt_o
interface pwm_clk_div_if import pwm_pkg::*; #(parameter int DIV_W = pwm_pkg::DIV_W);
    logic div_en, div_clr, divisor_wr, tick_o, pend_o;
    logic [DIV_W-1:0] divisor_i, div_active_o, tick_cnt_o;
    modport master(output div_en, div_clr, divisor_i, divisor_wr, input tick_o, div_active_o, pend_o, tick_cnt_o);
    modport slave(input div_en, div_clr, divisor_i, divisor_wr, output tick_o, div_active_o, pend_o, tick_cnt_o);
endinterface

// File: rtl/pwm_dbuf_reg.sv
// pwm_dbuf_reg: pending/active double-buffer (clk, rst_n, apply, wr, d -> active, pend); write on apply edge bypasses to active
module pwm_dbuf_reg #(parameter int W = 16) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         apply,
    input  logic         wr,
    input  logic [W-1:0] d,
    output logic [W-1:0] active,
    output logic         pend
);
    logic [W-1:0] pending;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pending <= '0;
            active <= '0;
            pend <= 1'b0;
        end else begin
            pending <= wr ? d : pending;
            active <= !apply ? active : wr ? d : pend ? pending : active;
            pend <= !apply && (wr || pend);
        end
endmodule

// File: rtl/pwm_clk_div.sv
// pwm_clk_div: divides clk by a double-buffered divisor into a one-cycle tick (clk, rst_n, bus slave: controls in, tick/status out)
module pwm_clk_div import pwm_pkg::*; #(parameter int DIV_W = pwm_pkg::DIV_W) (
    input logic          clk,
    input logic          rst_n,
    pwm_clk_div_if.slave bus
);
    logic [DIV_W-1:0] cnt, n_m1, tick_cnt;
    logic term, apply, fire, tick;
    mode_e mode;
    always_comb begin
        mode = bus.div_en ? RUN : IDLE;
        n_m1 = last_cnt(bus.div_active_o);
        term = cnt >= n_m1;
        apply = bus.div_clr || mode == IDLE || term;
        fire = !bus.div_clr && mode == RUN && term;
    end
    pwm_dbuf_reg #(.W(DIV_W)) u_div (
        .clk(clk),
        .rst_n(rst_n),
        .apply(apply),
        .wr(bus.divisor_wr),
        .d(bus.divisor_i),
        .active(bus.div_active_o),
        .pend(bus.pend_o)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt <= '0;
            tick <= 1'b0;
            tick_cnt <= '0;
        end else begin
            cnt <= apply ? '0 : cnt + 1'b1;
            tick <= fire;
            tick_cnt <= fire ? tick_cnt + 1'b1 : tick_cnt;
        end
    assign bus.tick_o = tick;
    assign bus.tick_cnt_o = tick_cnt;
endmodule

// File: tb/tb_pwm_clk_div.sv
// tb_pwm_clk_div: directed and random stimulus against an interval-level reference model
module tb_pwm_clk_div;
    import pwm_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    pwm_clk_div_if bus();
    pwm_clk_div dut(.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    int n_chk = 0;
    int n_fail = 0;
    int m_act, m_pval, m_el, m_tcnt;
    bit m_pend, m_tick;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask
    task automatic model_reset();
        m_act = 0;
        m_pval = 0;
        m_el = 0;
        m_tcnt = 0;
        m_pend = 0;
        m_tick = 0;
    endtask
    task automatic check_all();
        check("tick", 32'(bus.tick_o), 32'(m_tick));
        check("active", 32'(bus.div_active_o), m_act);
        check("pend", 32'(bus.pend_o), 32'(m_pend));
        check("tick_cnt", 32'(bus.tick_cnt_o), m_tcnt);
    endtask
    task automatic drive(input bit en, input bit clr, input bit wr, input int d);
        int n;
        bit done, bnd;
        bus.div_en = en;
        bus.div_clr = clr;
        bus.divisor_wr = wr;
        bus.divisor_i = DIV_W'(d);
        @(posedge clk);
        n = m_act < 2 ? 1 : m_act;
        done = m_el + 1 >= n;
        m_tick = en && !clr && done;
        bnd = !en || clr || done;
        m_el = bnd ? 0 : m_el + 1;
        if (m_tick) m_tcnt = (m_tcnt + 1) % 65536;
        if (bnd) begin
            if (wr) m_act = d;
            else if (m_pend) m_act = m_pval;
            m_pend = 0;
        end else if (wr) begin
            m_pval = d;
            m_pend = 1;
        end
        #1;
        check_all();
    endtask
    initial begin
        int prev;
        bus.div_en = 0;
        bus.div_clr = 0;
        bus.divisor_wr = 0;
        bus.divisor_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        drive(0, 0, 1, 4);
        check("idle_write_active", 32'(bus.div_active_o), 4);
        repeat (12) drive(1, 0, 0, 0);
        check("n4_tick_cnt", 32'(bus.tick_cnt_o), 3);
        drive(0, 0, 1, 0);
        repeat (5) drive(1, 0, 0, 0);
        drive(0, 0, 1, 1);
        prev = int'(bus.tick_cnt_o);
        repeat (65536) drive(1, 0, 0, 0);
        check("wrap_tick_cnt", 32'(bus.tick_cnt_o), 32'(prev));
        drive(0, 0, 1, 10);
        repeat (2) drive(1, 0, 0, 0);
        drive(1, 0, 1, 3);
        check("shrink_pend", 32'(bus.pend_o), 1);
        repeat (20) drive(1, 0, 0, 0);
        drive(0, 0, 1, 8);
        repeat (7) drive(1, 0, 0, 0);
        drive(1, 0, 1, 5);
        check("bypass_tick", 32'(bus.tick_o), 1);
        check("bypass_active", 32'(bus.div_active_o), 5);
        check("bypass_pend", 32'(bus.pend_o), 0);
        repeat (12) drive(1, 0, 0, 0);
        drive(0, 0, 1, 8);
        repeat (6) drive(1, 0, 0, 0);
        prev = int'(bus.tick_cnt_o);
        drive(1, 1, 0, 0);
        check("clr_no_tick", 32'(bus.tick_o), 0);
        check("clr_tick_cnt", 32'(bus.tick_cnt_o), 32'(prev));
        repeat (10) drive(1, 0, 0, 0);
        drive(0, 0, 1, 10);
        repeat (3) drive(1, 0, 0, 0);
        drive(1, 0, 1, 4);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) drive(1, 0, 0, 0);
        check("post_reset_tick", 32'(bus.tick_o), 1);
        repeat (3000)
            drive($urandom_range(9, 0) != 0, $urandom_range(19, 0) == 0,
                  $urandom_range(9, 0) == 0, int'($urandom_range(12, 0)));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
